// File: rtl/seq_detect_1011_if.sv
// Serial-bit and detection-result bundle for the 1011 pattern detector.
// The upstream source (DFF stage / testbench) is the master, the detector is the slave.
interface seq_detect_1011_if #(
  parameter int CNT_W = 8
);
  logic             Din;
  logic             Din_valid;
  logic             CntClr;
  logic             Match;
  logic [CNT_W-1:0] MatchCount;
  logic [2:0]       State;

  modport master (
    output Din, Din_valid, CntClr,
    input  Match, MatchCount, State
  );

  modport slave (
    input  Din, Din_valid, CntClr,
    output Match, MatchCount, State
  );
endinterface

// File: rtl/seq_detect_1011.sv
// Moore FSM recognising the serial pattern 1-0-1-1, with a registered one-cycle
// match pulse and a saturating, synchronously clearable detection counter.
module seq_detect_1011 #(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic         Clk,
  input  logic         Clr,
  seq_detect_1011_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] S1    = 3'd1;
  localparam logic [2:0] S10   = 3'd2;
  localparam logic [2:0] S101  = 3'd3;
  localparam logic [2:0] S1011 = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic             r_match;
  logic             w_match_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             w_hit;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_state <= IDLE;
      r_match <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_match <= w_match_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.Din_valid) w_state_next = bus.Din ? S1    : IDLE;
      S1:      if (bus.Din_valid) w_state_next = bus.Din ? S1    : S10;
      S10:     if (bus.Din_valid) w_state_next = bus.Din ? S101  : IDLE;
      S101:    if (bus.Din_valid) w_state_next = bus.Din ? S1011 : S10;
      // Without overlap, the trailing "1" of a match cannot seed a new "10".
      S1011:   if (bus.Din_valid) w_state_next = bus.Din ? S1 : ((OVERLAP != 0) ? S10 : IDLE);
      default: w_state_next = IDLE;
    endcase
  end

  // A hit is exactly the valid edge that completes the pattern from S101.
  assign w_hit = bus.Din_valid && (r_state == S101) && bus.Din;

  always_comb begin
    w_match_next = w_hit;
    w_count_next = r_count;
    if (bus.CntClr) begin
      w_count_next = '0;
    end else if (w_hit && (r_count != CNT_MAX)) begin
      w_count_next = r_count + 1'b1;
    end
  end

  assign bus.State      = r_state;
  assign bus.Match      = r_match;
  assign bus.MatchCount = r_count;
endmodule

// File: tb/tb_seq_detect_1011.sv
// Directed-vector bench for seq_detect_1011: three instances (overlap, no overlap,
// 2-bit counter) share one input stream; expected values are hand-computed.
module tb_seq_detect_1011;
  logic Clk = 1'b0;
  logic Clr = 1'b0;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic cnt_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  seq_detect_1011_if #(.CNT_W(8)) if_a ();
  seq_detect_1011_if #(.CNT_W(8)) if_b ();
  seq_detect_1011_if #(.CNT_W(2)) if_c ();

  assign if_a.Din = din;  assign if_a.Din_valid = din_valid;  assign if_a.CntClr = cnt_clr;
  assign if_b.Din = din;  assign if_b.Din_valid = din_valid;  assign if_b.CntClr = cnt_clr;
  assign if_c.Din = din;  assign if_c.Din_valid = din_valid;  assign if_c.CntClr = cnt_clr;

  seq_detect_1011 #(.OVERLAP(1), .CNT_W(8)) dut_a (.Clk(Clk), .Clr(Clr), .bus(if_a.slave));
  seq_detect_1011 #(.OVERLAP(0), .CNT_W(8)) dut_b (.Clk(Clk), .Clr(Clr), .bus(if_b.slave));
  seq_detect_1011 #(.OVERLAP(1), .CNT_W(2)) dut_c (.Clk(Clk), .Clr(Clr), .bus(if_c.slave));

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic step(input logic d, input logic v, input logic c);
    @(negedge Clk);
    din = d; din_valid = v; cnt_clr = c;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Clr = 1'b1; din_valid = 1'b0; cnt_clr = 1'b0;
    @(negedge Clk);
    Clr = 1'b0;
  endtask

  bit pat[4]     = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit ovl[7]     = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  int st_exp[4]  = '{1, 2, 3, 4};
  int pulses_a;
  int pulses_b;

  initial begin
    // Reset asserted between edges takes effect immediately
    #12 Clr = 1'b1;
    #1;
    check("rst_state", if_a.State, 0);
    check("rst_match", if_a.Match, 0);
    check("rst_count", if_a.MatchCount, 0);
    @(posedge Clk); #1;
    check("rst_held_state", if_a.State, 0);
    @(negedge Clk);
    Clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check("idle_novalid_state", if_a.State, 0);
      check("idle_novalid_match", if_a.Match, 0);
    end
    check("idle_novalid_count", if_a.MatchCount, 0);

    // Basic detection
    for (int i = 0; i < 4; i++) begin
      step(pat[i], 1'b1, 1'b0);
      check("basic_state", if_a.State, st_exp[i]);
      check("basic_match", if_a.Match, (i == 3) ? 1 : 0);
    end
    check("basic_count_a", if_a.MatchCount, 1);
    check("basic_count_b", if_b.MatchCount, 1);
    step(1'b0, 1'b0, 1'b0);
    check("basic_pulse_end", if_a.Match, 0);
    check("basic_state_hold", if_a.State, 4);

    // Overlapping vs non-overlapping
    do_reset();
    pulses_a = 0; pulses_b = 0;
    for (int i = 0; i < 7; i++) begin
      step(ovl[i], 1'b1, 1'b0);
      pulses_a += int'(if_a.Match);
      pulses_b += int'(if_b.Match);
    end
    check("ovl1_pulses", pulses_a, 2);
    check("ovl1_count", if_a.MatchCount, 2);
    check("ovl1_state", if_a.State, 4);
    check("ovl0_pulses", pulses_b, 1);
    check("ovl0_count", if_b.MatchCount, 1);
    check("ovl0_state", if_b.State, 1);

    // Valid gaps: inverted data during gaps must be ignored
    do_reset();
    pulses_a = 0;
    for (int i = 0; i < 4; i++) begin
      step(pat[i], 1'b1, 1'b0);
      check("gap_state", if_a.State, st_exp[i]);
      pulses_a += int'(if_a.Match);
      for (int g = 0; g < 3; g++) begin
        step(~pat[i], 1'b0, 1'b0);
        check("gap_hold", if_a.State, st_exp[i]);
        pulses_a += int'(if_a.Match);
      end
    end
    check("gap_pulses", pulses_a, 1);
    check("gap_count", if_a.MatchCount, 1);

    // Saturation of the 2-bit counter, then clear colliding with a detection
    do_reset();
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 4; j++)
        step(pat[j], 1'b1, 1'b0);
    check("sat_count_c", if_c.MatchCount, 3);
    check("sat_count_a", if_a.MatchCount, 5);
    check("sat_count_b", if_b.MatchCount, 5);
    for (int j = 0; j < 3; j++)
      step(pat[j], 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("clr_hit_match_c", if_c.Match, 1);
    check("clr_hit_count_c", if_c.MatchCount, 0);
    check("clr_hit_match_a", if_a.Match, 1);
    check("clr_hit_count_a", if_a.MatchCount, 0);
    step(1'b0, 1'b0, 1'b0);
    check("clr_after_match", if_c.Match, 0);
    check("clr_after_count", if_c.MatchCount, 0);

    // Reset mid-pattern discards progress
    do_reset();
    for (int j = 0; j < 3; j++)
      step(pat[j], 1'b1, 1'b0);
    check("mid_state", if_a.State, 3);
    @(negedge Clk);
    din_valid = 1'b0;
    #2 Clr = 1'b1;
    #1;
    check("mid_rst_state", if_a.State, 0);
    @(negedge Clk);
    Clr = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    check("mid_after_state", if_a.State, 1);
    check("mid_after_match", if_a.Match, 0);
    check("mid_after_count", if_a.MatchCount, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
